seg_scan_driver: RTL

// - Upstream stage of the BCD-to-7-segment decoder on the 4-digit common-anode display.
// - Converts a binary value (the game score) to packed BCD with a sequential double-dabble engine.
// - Time-multiplexes the 4 digits: emits one BCD nibble at a time to the decoder and drives the matching active-low anode.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/seg_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit scanned 7-segment display path.
// Contents:
//   bcd_t          - one packed BCD digit
//   conv_state_t   - binary-to-BCD conversion FSM states
//   MAX_DISP       - largest value the display can show
//   N_DIGITS       - number of multiplexed digits
//   dabble_shift() - one double-dabble step: add-3 correction, then shift in one bit
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } conv_state_t;

    localparam int unsigned MAX_DISP = 9999;
    localparam int unsigned N_DIGITS = 4;

    // Every nibble >= 5 gets +3 so that the following left shift carries into the
    // next decimal digit. The bit shifted out of the top is always 0 for values
    // that fit in four digits, so the truncating cast is harmless.
    function automatic logic [15:0] dabble_shift(input logic [15:0] bcd, input logic in_bit);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return 16'({adj, in_bit});
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One conversion takes 1 cycle in IDLE (start accepted), BIN_W cycles in SHIFT
// and 1 cycle in LOAD; `done` is high during the LOAD cycle, when `bcd` holds
// the finished result.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a conversion of `bin` (only honoured in IDLE)
//   bin    in   BIN_W-bit binary value, expected <= 9999
//   busy   out  high from the cycle after start through the LOAD cycle
//   done   out  one-cycle pulse, result valid on `bcd`
//   bcd    out  packed 4-digit BCD scratch/result register
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state;
    logic [BIN_W-1:0] bin_sr;
    logic [15:0]      scratch;
    logic [CNT_W-1:0] shift_cnt;
    logic [15:0]      scratch_next;

    always_comb begin
        scratch_next = dabble_shift(scratch, bin_sr[BIN_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_sr    <= '0;
            scratch   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr    <= bin;
                        scratch   <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    bin_sr    <= bin_sr << 1;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CNT_W'(BIN_W - 1)) begin
                        done  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bcd = scratch;

endmodule

// File: rtl/seg_scan_driver.sv
// Score display front end: clamps and converts a binary value to BCD, keeps
// the last completed result in a display register, and time-multiplexes the
// four digits onto one BCD nibble plus active-low anode enables.
// Build option: define LEAD_ZERO_BLANK_EN to darken digits above the most
// significant nonzero digit (the ones digit is always lit).
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   value      in   binary value to display (clamped to 9999)
//   value_vld  in   one-cycle strobe qualifying `value`
//   busy       out  conversion in progress
//   bcd_digit  out  BCD nibble for the current digit slot
//   an         out  active-low anode enables, an[0] = ones digit
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BIN_W       = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             value_vld,
    output logic             busy,
    output bcd_t             bcd_digit,
    output logic [3:0]       an
);

    localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

    logic [BIN_W-1:0]  value_clamped;
    logic              pend_vld;
    logic [BIN_W-1:0]  pend_val;
    logic              conv_start;
    logic [BIN_W-1:0]  conv_bin;
    logic              conv_busy;
    logic              conv_done;
    logic [15:0]       conv_bcd;
    logic [15:0]       display_q;
    logic [RCNT_W-1:0] refresh_cnt;
    logic [1:0]        slot_q;
    logic [3:0]        an_d;
    bcd_t              digit_d;

    always_comb begin
        value_clamped = (32'(value) > MAX_DISP) ? BIN_W'(MAX_DISP) : value;
    end

    // A fresh strobe in IDLE beats a stale pending value (latest wins).
    always_comb begin
        conv_start = !conv_busy && (value_vld || pend_vld);
        conv_bin   = value_vld ? value_clamped : pend_val;
    end

    // Strobes during a conversion (LOAD cycle included) park here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_val <= '0;
        end else if (value_vld && conv_busy) begin
            pend_vld <= 1'b1;
            pend_val <= value_clamped;
        end else if (conv_start) begin
            pend_vld <= 1'b0;
        end
    end

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy = conv_busy;

    // Only a completed conversion ever reaches the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q <= 16'h0000;
        end else if (conv_done) begin
            display_q <= conv_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            slot_q      <= 2'd0;
        end else if (refresh_cnt == RCNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            slot_q      <= slot_q + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [1:0] msd;

    // Index of the most significant nonzero digit; 0 when the value is 0.
    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < int'(N_DIGITS); i++) begin
            if (display_q[4*i +: 4] != 4'd0) begin
                msd = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        an_d    = ~(4'b0001 << slot_q);
        digit_d = display_q[{slot_q, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        if (slot_q > msd) begin
            an_d = 4'b1111;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= 4'b1111;
            bcd_digit <= 4'd0;
        end else begin
            an        <= an_d;
            bcd_digit <= digit_d;
        end
    end

endmodule
